// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port data memory.
// The arbiter takes the slave view; the masters/memory environment takes the master view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic          owner;
    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rd,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_we, mem_a, mem_wd,
        output owner, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rd,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_we, mem_a, mem_wd,
        input  owner, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for the single-port dmem: IDLE -> ACCESS -> RESP, ack 2 cycles
// after the sampling edge, one transaction per 3 cycles; masters hold req until they see ack.
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant;
    logic          win;
    logic          owner_q;
    logic          lat_we;
    logic [AW-1:0] lat_a;
    logic [DW-1:0] lat_wd;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Under contention the master that did not win last time goes first.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = owner_q;
        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    grant     = 1'b1;
                    win       = (bus.m0_req && bus.m1_req) ? ~owner_q : bus.m1_req;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= 1'b1;
            lat_we  <= 1'b0;
            lat_a   <= '0;
            lat_wd  <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            if (grant) begin
                owner_q <= win;
                lat_we  <= win ? bus.m1_we    : bus.m0_we;
                lat_a   <= win ? bus.m1_addr  : bus.m0_addr;
                lat_wd  <= win ? bus.m1_wdata : bus.m0_wdata;
            end
            if (state == ACCESS && !lat_we) begin
                if (owner_q) begin
                    rdata1 <= bus.mem_rd;
                end else begin
                    rdata0 <= bus.mem_rd;
                end
            end
        end
    end

    // Write strobe comes only from registers, so an async reset kills it within the cycle.
    assign bus.mem_we   = (state == ACCESS) && lat_we;
    assign bus.mem_a    = lat_a;
    assign bus.mem_wd   = lat_wd;
    assign bus.m0_ack   = (state == RESP) && !owner_q;
    assign bus.m1_ack   = (state == RESP) &&  owner_q;
    assign bus.m0_rdata = rdata0;
    assign bus.m1_rdata = rdata1;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model (service order, memory image, read data).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus();

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural dmem: combinational read, write on the rising edge.
    logic [31:0] ram [0:255] = '{default: 32'h0};
    assign bus.mem_rd = ram[bus.mem_a[9:2]];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_a[9:2]] <= bus.mem_wd;
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] ram_m [0:255] = '{default: 32'h0};
    logic        last_owner;
    logic [31:0] exp_rd [2];

    task automatic idle_inputs();
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    endtask

    task automatic model_reset();
        last_owner = 1'b1;
        exp_rd[0]  = 32'h0;
        exp_rd[1]  = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One arbitration round from a quiet IDLE: drive the requesting masters, watch 7 cycles.
    task automatic run_round(input logic r0, input logic r1,
                             input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                             input logic we1, input logic [31:0] a1, input logic [31:0] d1);
        logic        rq [2];
        logic        wq [2];
        logic [31:0] aq [2];
        logic [31:0] dq [2];
        int          order [$];
        int          exp_cyc [2];
        int          ack_cyc [2];
        int          ack_cnt [2];
        int          exp_we;
        int          we_cnt;
        logic        ack;
        rq[0] = r0; wq[0] = we0; aq[0] = a0; dq[0] = d0;
        rq[1] = r1; wq[1] = we1; aq[1] = a1; dq[1] = d1;
        exp_cyc[0] = -1; exp_cyc[1] = -1;
        ack_cyc[0] = -1; ack_cyc[1] = -1;
        ack_cnt[0] = 0;  ack_cnt[1] = 0;
        exp_we = 0; we_cnt = 0;

        if (r0 && r1)  order = '{last_owner ? 0 : 1, last_owner ? 1 : 0};
        else if (r0)   order = '{0};
        else if (r1)   order = '{1};
        foreach (order[k]) begin
            int m;
            m = order[k];
            exp_cyc[m] = 2 + 3 * k;
            if (wq[m]) begin
                ram_m[aq[m][9:2]] = dq[m];
                exp_we++;
            end else begin
                exp_rd[m] = ram_m[aq[m][9:2]];
            end
            last_owner = m[0];
        end

        bus.m0_req = r0; bus.m0_we = we0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = we1; bus.m1_addr = a1; bus.m1_wdata = d1;

        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (bus.mem_we) we_cnt++;
            for (int m = 0; m < 2; m++) begin
                if (exp_cyc[m] - 1 == c) begin
                    total++;
                    if (bus.mem_a !== aq[m] || bus.busy !== 1'b1 || bus.mem_we !== wq[m]) begin
                        bad++;
                        $display("FAIL access_m%0d c=%0d: mem_a=%h busy=%b we=%b, want mem_a=%h busy=1 we=%b",
                                 m, c, bus.mem_a, bus.busy, bus.mem_we, aq[m], wq[m]);
                    end
                    if (wq[m]) begin
                        total++;
                        if (bus.mem_wd !== dq[m]) begin
                            bad++;
                            $display("FAIL mem_wd_m%0d: got %h want %h", m, bus.mem_wd, dq[m]);
                        end
                    end
                end
                ack = (m == 0) ? bus.m0_ack : bus.m1_ack;
                if (ack) begin
                    ack_cnt[m]++;
                    if (ack_cyc[m] < 0) ack_cyc[m] = c;
                    total++;
                    if (((m == 0) ? bus.m0_rdata : bus.m1_rdata) !== exp_rd[m]) begin
                        bad++;
                        $display("FAIL rdata_at_ack_m%0d: got %h want %h", m,
                                 (m == 0) ? bus.m0_rdata : bus.m1_rdata, exp_rd[m]);
                    end
                    if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
                end
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;

        for (int m = 0; m < 2; m++) begin
            total++;
            if (ack_cyc[m] != exp_cyc[m] || ack_cnt[m] != (rq[m] ? 1 : 0)) begin
                bad++;
                $display("FAIL ack_timing_m%0d: first ack cycle %0d count %0d, want cycle %0d count %0d",
                         m, ack_cyc[m], ack_cnt[m], exp_cyc[m], rq[m] ? 1 : 0);
            end
        end
        total++;
        if (we_cnt != exp_we) begin
            bad++;
            $display("FAIL mem_we_cycles: got %0d want %0d", we_cnt, exp_we);
        end
        total++;
        if (bus.owner !== last_owner || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL owner_after_round: owner=%b busy=%b, want owner=%b busy=0",
                     bus.owner, bus.busy, last_owner);
        end
    endtask

    task automatic test_reset();
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3C, 32'hA5A5_0F0F);
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h3C, 32'h0);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h3C;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0 || bus.m0_rdata !== 32'h0 ||
            bus.m1_rdata !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_a !== 32'h0 ||
            bus.mem_wd !== 32'h0 || bus.busy !== 1'b0 || bus.owner !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: ack=%b%b rd0=%h rd1=%h we=%b a=%h wd=%h busy=%b owner=%b, want all 0 and owner=1",
                     bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata, bus.mem_we,
                     bus.mem_a, bus.mem_wd, bus.busy, bus.owner);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_write_read();
        run_round(1'b1, 1'b0, 1'b1, 32'h50, 32'h0000_0007, 1'b0, 32'h0, 32'h0);
        run_round(1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 1'b0, 32'h0, 32'h0);
        total++;
        if (bus.m0_rdata !== 32'h0000_0007) begin
            bad++;
            $display("FAIL write_read_m0: rdata %h want 00000007", bus.m0_rdata);
        end
    endtask

    task automatic test_contention_from_reset();
        do_reset();
        run_round(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 32'h3C, 32'h0);
        total++;
        if (bus.owner !== 1'b1) begin
            bad++;
            $display("FAIL contention_owner: owner %b want 1", bus.owner);
        end
        run_round(1'b1, 1'b1, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h50, 32'h0);
    endtask

    task automatic test_continuous_contention();
        int seen_m [$];
        int seen_c [$];
        int first;
        first = last_owner ? 0 : 1;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h50;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h3C;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (bus.m0_ack) begin seen_m.push_back(0); seen_c.push_back(c); end
            if (bus.m1_ack) begin seen_m.push_back(1); seen_c.push_back(c); end
            if (seen_m.size() >= 4) begin
                bus.m0_req = 1'b0;
                bus.m1_req = 1'b0;
            end
        end
        exp_rd[0] = ram_m[8'h14];
        exp_rd[1] = ram_m[8'h0F];
        total++;
        if (seen_m.size() != 4) begin
            bad++;
            $display("FAIL continuous_ack_count: got %0d want 4", seen_m.size());
        end
        for (int k = 0; k < 4 && k < seen_m.size(); k++) begin
            total++;
            if (seen_m[k] != ((k % 2 == 0) ? first : 1 - first) || seen_c[k] != 2 + 3 * k) begin
                bad++;
                $display("FAIL continuous_grant_%0d: master %0d at cycle %0d, want master %0d at cycle %0d",
                         k, seen_m[k], seen_c[k], (k % 2 == 0) ? first : 1 - first, 2 + 3 * k);
            end
        end
        last_owner = first[0] ^ 1'b1;
        total++;
        if (bus.m0_rdata !== exp_rd[0] || bus.m1_rdata !== exp_rd[1]) begin
            bad++;
            $display("FAIL continuous_rdata: %h %h want %h %h",
                     bus.m0_rdata, bus.m1_rdata, exp_rd[0], exp_rd[1]);
        end
    endtask

    task automatic test_write_isolation();
        logic [31:0] m1_prev;
        run_round(1'b1, 1'b0, 1'b1, 32'h44, 32'h1122_3344, 1'b0, 32'h0, 32'h0);
        m1_prev = exp_rd[1];
        run_round(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 32'h54, 32'hDEAD_BEEF);
        total++;
        if (bus.m0_rdata !== 32'h1122_3344 || bus.m1_rdata !== m1_prev || ram[21] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL write_isolation: m0_rdata=%h m1_rdata=%h ram21=%h, want 11223344 %h deadbeef",
                     bus.m0_rdata, bus.m1_rdata, ram[21], m1_prev);
        end
    endtask

    task automatic test_reset_mid_write();
        int acks;
        acks = 0;
        run_round(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h48, 32'hCAFE_0001);
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h48; bus.m0_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        total++;
        if (bus.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_write_access: mem_we %b want 1", bus.mem_we);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL mid_write_we_drop: mem_we %b want 0", bus.mem_we);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack) acks++;
        end
        idle_inputs();
        reset = 1'b0;
        model_reset();
        total++;
        if (ram[18] !== 32'hCAFE_0001 || acks != 0) begin
            bad++;
            $display("FAIL mid_write_abort: ram18=%h acks=%0d, want cafe0001 and 0", ram[18], acks);
        end
        run_round(1'b1, 1'b0, 1'b1, 32'h48, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
        total++;
        if (ram[18] !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mid_write_reissue: ram18=%h want 12345678", ram[18]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          pat;
            logic [31:0] a0, a1;
            pat = $urandom_range(3, 1);
            a0  = {24'h0, 2'b0, 4'($urandom_range(15, 0)), 2'($urandom)};
            a1  = {24'h0, 2'b0, 4'($urandom_range(15, 0)), 2'($urandom)};
            run_round(pat[0], pat[1], 1'($urandom), a0, $urandom,
                      1'($urandom), a1, $urandom);
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_write_read();
        test_contention_from_reset();
        test_continuous_contention();
        test_write_isolation();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
